// File: rtl/mem_latency_responder_pkg.sv
// Shared constants and FSM state encoding for the memory latency responder.
// Takes the place of the old custom_opcodes.v include: word size, block size
// and the MEMST_* state names live here so every file agrees on them.
package mem_latency_responder_pkg;

    localparam int MEM_WORD_SIZE  = 16;
    localparam int MEM_BLOCK_BITS = 2;

    typedef enum logic [1:0] {
        MEMST_IDLE = 2'd0,
        MEMST_BUSY = 2'd1,
        MEMST_DONE = 2'd2
    } mem_state_e;

    // Larger of two latencies, used to size the wait counter.
    function automatic int max_latency(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_latency_responder_ram.sv
// Word-addressed RAM behind the responder: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module mem_word_ram #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    // Commit a word on the clock edge when the write strobe is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_latency_responder.sv
// Memory-side responder for the readM/writeM/address/data/ready port.
// Each request is answered after a programmable number of BUSY cycles;
// ready pulses for one DONE cycle and read data is driven onto the shared
// bus only in that cycle. Defining MEM_BURST_EN shortens sequential
// in-block reads to BURST_LATENCY cycles.
module mem_latency_responder #(
    parameter int WORD_SIZE     = mem_latency_responder_pkg::MEM_WORD_SIZE,
    parameter int ADDR_BITS     = 12,
    parameter int LATENCY       = 4,
    parameter int BURST_LATENCY = 1,
    parameter int BLOCK_BITS    = mem_latency_responder_pkg::MEM_BLOCK_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 ready,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);
    import mem_latency_responder_pkg::*;

    localparam int CNT_W = $clog2(max_latency(LATENCY, BURST_LATENCY)) + 1;

    mem_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]          rd_count_q, rd_count_d;
    logic [15:0]          wr_count_q, wr_count_d;

    logic                 req_valid;
    logic                 req_match;
    logic [ADDR_BITS-1:0] req_addr;
    logic [CNT_W-1:0]     start_cnt;
    logic                 commit;
    logic                 ram_we;
    logic [WORD_SIZE-1:0] ram_rdata;
    logic                 unused_addr_bits;

    // A simultaneous read and write is treated as a write, so writeM alone
    // decides the operation; upper address bits alias into the RAM.
    assign req_valid        = readM | writeM;
    assign req_addr         = address[ADDR_BITS-1:0];
    assign req_match        = req_valid && (writeM == op_q) && (req_addr == addr_q);
    assign unused_addr_bits = ^address[WORD_SIZE-1:ADDR_BITS];

`ifdef MEM_BURST_EN
    logic                 burst_ok_q, burst_ok_d;
    logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 burst_hit;

    assign next_addr = last_addr_q + 1'b1;
    assign burst_hit = burst_ok_q && readM && !writeM && (req_addr == next_addr)
                       && (req_addr[BLOCK_BITS-1:0] != '0);
    assign start_cnt = burst_hit ? CNT_W'(BURST_LATENCY - 1) : CNT_W'(LATENCY - 1);

    // Eligibility lasts only for the IDLE cycle right after a completed read.
    always_comb begin
        burst_ok_d  = (state_q == MEMST_DONE) && req_match && !op_q;
        last_addr_d = burst_ok_d ? addr_q : last_addr_q;
    end

    // Burst tracking registers, cleared by reset like the rest of the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_ok_q  <= 1'b0;
            last_addr_q <= '0;
        end else begin
            burst_ok_q  <= burst_ok_d;
            last_addr_q <= last_addr_d;
        end
    end
`else
    logic unused_burst_cfg;

    assign start_cnt        = CNT_W'(LATENCY - 1);
    assign unused_burst_cfg = (BLOCK_BITS > 0);
`endif

    // Next-state, latch and counter logic; ready is combinational in DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        ready      = 1'b0;
        commit     = 1'b0;
        case (state_q)
            MEMST_IDLE: begin
                if (req_valid) begin
                    op_d    = writeM;
                    addr_d  = req_addr;
                    cnt_d   = start_cnt;
                    state_d = MEMST_BUSY;
                end
            end
            MEMST_BUSY: begin
                if (!req_valid) begin
                    state_d = MEMST_IDLE;
                end else if (!req_match) begin
                    op_d   = writeM;
                    addr_d = req_addr;
                    cnt_d  = CNT_W'(LATENCY - 1);
                end else if (cnt_q == '0) begin
                    state_d = MEMST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MEMST_DONE: begin
                state_d = MEMST_IDLE;
                if (req_match) begin
                    ready  = 1'b1;
                    commit = 1'b1;
                    if (op_q) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end else begin
                        rd_count_d = rd_count_q + 1'b1;
                    end
                end
            end
            default: state_d = MEMST_IDLE;
        endcase
    end

    // State, latch and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= MEMST_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // A reset landing on the DONE edge must not let the write through.
    assign ram_we = commit && op_q && reset_n;

    mem_word_ram #(
        .WIDTH     (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (data),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    // Only a matching read in DONE owns the bus; a write never does.
    assign data     = (ready && !op_q) ? ram_rdata : {WORD_SIZE{1'bz}};
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder (LATENCY=4, BURST_LATENCY=1).
// Burst expectations follow MEM_BURST_EN when it is defined.
module tb_mem_latency_responder;

    localparam int LAT_FULL = 5;
`ifdef MEM_BURST_EN
    localparam int LAT_BURST = 2;
`else
    localparam int LAT_BURST = 5;
`endif
    localparam int MAX_WAIT = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        readM = 1'b0;
    logic        writeM = 1'b0;
    logic [15:0] address = '0;
    wire  [15:0] data;
    logic        ready;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] tb_val = '0;
    logic        tb_en = 1'b0;

    int checks_total = 0;
    int checks_passed = 0;

    assign data = tb_en ? tb_val : 16'bz;

    mem_latency_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .readM    (readM),
        .writeM   (writeM),
        .address  (address),
        .data     (data),
        .ready    (ready),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed hang expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        readM   = rd;
        writeM  = wr;
        address = addr;
        tb_val  = wdata;
        tb_en   = wr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Count cycles from the current one until ready; leaves time at negedge+1.
    task automatic waitReady(output int cycles, output bit ok);
        cycles = -1;
        ok = 1'b0;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #1;
            if (ready === 1'b1) begin
                cycles = c;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic doAccess(input string tag, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input int exp_lat, input logic [15:0] exp_data);
        int  c;
        bit  ok;
        applyStimulus(rd, wr, addr, wdata);
        waitReady(c, ok);
        checkOutput({tag, "_latency"}, ok ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (ok && rd) checkOutput({tag, "_data"}, {16'h0, data}, {16'h0, exp_data});
        @(negedge clk);
    endtask

    initial begin
        int  c;
        bit  ok;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", {31'h0, ready}, 32'h0);
        checkOutput("reset_rd_count", {16'h0, rd_count}, 32'h0);
        checkOutput("reset_wr_count", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic write then read at 0x0010
        doAccess("t1_wr", 1'b0, 1'b1, 16'h0010, 16'h1234, LAT_FULL, 16'h0);
        checkOutput("t1_wr_count", {16'h0, wr_count}, 32'd1);
        doAccess("t1_rd", 1'b1, 1'b0, 16'h0010, 16'h0, LAT_FULL, 16'h1234);
        checkOutput("t1_rd_count", {16'h0, rd_count}, 32'd1);
        doAccess("t3_prep", 1'b0, 1'b1, 16'h0011, 16'h5A5A, LAT_FULL, 16'h0);

        // Address change in BUSY cycle 2 restarts the access
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0);
        waitReady(c, ok);
        checkOutput("t3_restart_latency", ok ? 32'(c) : 32'hFFFF_FFFF, 32'd5);
        if (ok) checkOutput("t3_data", {16'h0, data}, 32'h5A5A);
        @(negedge clk);
        checkOutput("t3_rd_count", {16'h0, rd_count}, 32'd2);

        // Read held across completion: serviced twice, one IDLE cycle between
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < 12; i++) begin
            #1;
            checkOutput($sformatf("t2_ready_c%0d", i), {31'h0, ready},
                        (i == 5 || i == 11) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checkOutput("t2_rd_count", {16'h0, rd_count}, 32'd4);
        @(negedge clk);

        // Block reads 0x0020..0x0023, then 0x0024 crosses the block
        for (int i = 0; i < 5; i++) begin
            doAccess($sformatf("t4_wr%0d", i), 1'b0, 1'b1, 16'(16'h0020 + i),
                     16'(16'hA0 + i), LAT_FULL, 16'h0);
        end
        for (int i = 0; i < 5; i++) begin
            doAccess($sformatf("t4_rd%0d", i), 1'b1, 1'b0, 16'(16'h0020 + i), 16'h0,
                     (i == 0 || i == 4) ? LAT_FULL : LAT_BURST, 16'(16'hA0 + i));
        end
        checkOutput("t4_rd_count", {16'h0, rd_count}, 32'd9);

        // Upper address bits alias onto the RAM
        doAccess("alias_wr", 1'b0, 1'b1, 16'h1040, 16'h7777, LAT_FULL, 16'h0);
        doAccess("alias_rd", 1'b1, 1'b0, 16'h0040, 16'h0, LAT_FULL, 16'h7777);

        // Reset during the DONE cycle of a write aborts it
        doAccess("t5_prep", 1'b0, 1'b1, 16'h0030, 16'h1111, LAT_FULL, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'hBEEF);
        waitReady(c, ok);
        checkOutput("t5_wr_latency", ok ? 32'(c) : 32'hFFFF_FFFF, 32'd5);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checkOutput("t5_ready_after", {31'h0, ready}, 32'h0);
        checkOutput("t5_wr_count", {16'h0, wr_count}, 32'h0);
        checkOutput("t5_rd_count", {16'h0, rd_count}, 32'h0);
        @(negedge clk);
        doAccess("t5_rd", 1'b1, 1'b0, 16'h0030, 16'h0, LAT_FULL, 16'h1111);
        checkOutput("t5_rd_count_after", {16'h0, rd_count}, 32'd1);

        // Read counter wraps from 0xFFFF to 0x0000
        force dut.rd_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.rd_count_q;
        doAccess("t6_rd", 1'b1, 1'b0, 16'h0010, 16'h0, LAT_FULL, 16'h1234);
        checkOutput("t6_rd_wrap", {16'h0, rd_count}, 32'h0);

        // DUT must never drive the bus while a write is in progress
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput($sformatf("t6_bus_c%0d", i), {16'h0, data}, 32'h0);
            if (i == 5) checkOutput("t6_wr_ready", {31'h0, ready}, 32'h1);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checkOutput("t6_wr_count", {16'h0, wr_count}, 32'd1);
        @(negedge clk);
        doAccess("t6_rd_back", 1'b1, 1'b0, 16'h0010, 16'h0, LAT_FULL, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
